deposit_ledger: RTL

//  Parametrised successor to the single-pulse deposit FSM. Per customer session: loads the

---
 rtl/atm_pkg.sv | 19 +
 rtl/deposit_ledger_if.sv | 36 +++
 rtl/rise_detect.sv | 25 ++
 rtl/deposit_ledger.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the deposit ledger.
//   state_e   : ledger FSM states
//   ERR_*     : err_code values reported with a rejected deposit
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        HOLD   = 3'd4
    } state_e;

    localparam logic [1:0] ERR_ZERO  = 2'd0;
    localparam logic [1:0] ERR_LIMIT = 2'd1;
    localparam logic [1:0] ERR_COUNT = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

endpackage

// File: rtl/deposit_ledger_if.sv
// Session/deposit bus between the front-end (master) and the ledger (slave).
//   session_start/session_end : session control pulses
//   balance_in                : opening balance
//   dep_en/dep_amt            : deposit request level and amount
//   count_up/err/err_code     : result pulses and rejection reason
//   balance/dep_cnt           : running balance and committed deposit count
//   busy/active               : FSM status
interface deposit_ledger_if #(
    parameter int unsigned AMT_W = 16,
    parameter int unsigned BAL_W = 24,
    parameter int unsigned CNT_W = 4
);
    logic             session_start;
    logic             session_end;
    logic [BAL_W-1:0] balance_in;
    logic             dep_en;
    logic [AMT_W-1:0] dep_amt;
    logic             count_up;
    logic [BAL_W-1:0] balance;
    logic [CNT_W-1:0] dep_cnt;
    logic             busy;
    logic             active;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output session_start, session_end, balance_in, dep_en, dep_amt,
        input  count_up, balance, dep_cnt, busy, active, err, err_code
    );

    modport slave (
        input  session_start, session_end, balance_in, dep_en, dep_amt,
        output count_up, balance, dep_cnt, busy, active, err, err_code
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector with synchronous active-high reset.
//   clk  : clock
//   res  : synchronous reset, clears the history flop
//   d    : level input
//   rise : d high now and low on the previous cycle
module rise_detect (
    input  logic clk,
    input  logic res,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (res) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/deposit_ledger.sv
// Per-session deposit ledger: loads an opening balance, validates edge-triggered deposits
// against amount, count and overflow limits, and commits accepted ones to the balance.
//   clk : clock, all state on posedge
//   res : synchronous active-high reset
//   bus : deposit_ledger_if slave (session control, deposit request, results, status)
module deposit_ledger
    import atm_pkg::*;
#(
    parameter int unsigned AMT_W   = 16,
    parameter int unsigned BAL_W   = 24,
    parameter int unsigned MAX_DEP = 10000,
    parameter int unsigned MAX_TXN = 8
) (
    input logic              clk,
    input logic              res,
    deposit_ledger_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_TXN + 1);

    state_e           state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             end_pend_q, end_pend_d;
    logic             count_up_q, count_up_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             rise;
    logic [BAL_W:0]   sum;

    rise_detect u_rise_detect (
        .clk  (clk),
        .res  (res),
        .d    (bus.dep_en),
        .rise (rise)
    );

    // One extra bit so an overflowing deposit is caught instead of wrapping.
    assign sum = {1'b0, balance_q} + (BAL_W+1)'(amt_q);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= IDLE;
            balance_q  <= '0;
            cnt_q      <= '0;
            amt_q      <= '0;
            end_pend_q <= 1'b0;
            count_up_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_ZERO;
        end else begin
            state_q    <= state_d;
            balance_q  <= balance_d;
            cnt_q      <= cnt_d;
            amt_q      <= amt_d;
            end_pend_q <= end_pend_d;
            count_up_q <= count_up_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        balance_d  = balance_q;
        cnt_d      = cnt_q;
        amt_d      = amt_q;
        end_pend_d = end_pend_q;
        count_up_d = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        unique case (state_q)
            IDLE: begin
                end_pend_d = 1'b0;
                if (bus.session_start) begin
                    balance_d = bus.balance_in;
                    cnt_d     = '0;
                    state_d   = READY;
                end
            end
            READY: begin
                // Closing the session wins over a simultaneous deposit request.
                if (bus.session_end) begin
                    state_d = IDLE;
                end else if (rise) begin
                    amt_d   = bus.dep_amt;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bus.session_end) begin
                    end_pend_d = 1'b1;
                end
                state_d = HOLD;
                err_d   = 1'b1;
                if (amt_q == '0) begin
                    err_code_d = ERR_ZERO;
                end else if (amt_q > AMT_W'(MAX_DEP)) begin
                    err_code_d = ERR_LIMIT;
                end else if (cnt_q == CNT_W'(MAX_TXN)) begin
                    err_code_d = ERR_COUNT;
                end else if (sum[BAL_W]) begin
                    err_code_d = ERR_OVF;
                end else begin
                    err_d   = 1'b0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (bus.session_end) begin
                    end_pend_d = 1'b1;
                end
                balance_d  = sum[BAL_W-1:0];
                cnt_d      = cnt_q + CNT_W'(1);
                count_up_d = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (bus.session_end || end_pend_q) begin
                    end_pend_d = 1'b0;
                    state_d    = IDLE;
                end else if (!bus.dep_en) begin
                    state_d = READY;
                end
            end
            default: begin
                end_pend_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign bus.count_up = count_up_q;
    assign bus.balance  = balance_q;
    assign bus.dep_cnt  = cnt_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
    assign bus.busy     = (state_q == CHECK) || (state_q == COMMIT);
    assign bus.active   = (state_q != IDLE);

endmodule
